// File: rtl/noobs_cpu_pkg.sv
// Shared definitions for the noobs 8-bit multicycle CPU: opcodes, FSM states
// and the instruction-length decode used by both fetch and operand phases.
package noobs_cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_CMP = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_LD  = 4'h9;
    localparam logic [3:0] OP_ST  = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_JC  = 4'hD;
    localparam logic [3:0] OP_RSV = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_OPR1,
        ST_OPR2,
        ST_EXEC,
        ST_HALT
    } cpu_state_t;

    function automatic logic [1:0] instr_len(input logic [3:0] op);
        logic [1:0] len;
        case (op)
            OP_LDI, OP_JMP, OP_JZ, OP_JC: len = 2'd2;
            OP_LD, OP_ST:                 len = 2'd3;
            default:                      len = 2'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/noobs_cpu_alu.sv
// Combinational ALU for the noobs CPU; C is carry for ADD and borrow for SUB/CMP.
module noobs_cpu_alu
    import noobs_cpu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] op,
    output logic [7:0] result,
    output logic       z,
    output logic       c
);

    always_comb begin
        result = 8'h00;
        c      = 1'b0;
        case (op)
            OP_ADD:         {c, result} = {1'b0, a} + {1'b0, b};
            OP_SUB, OP_CMP: {c, result} = {1'b0, a} - {1'b0, b};
            OP_AND:         result = a & b;
            OP_OR:          result = a | b;
            OP_XOR:         result = a ^ b;
            default:        result = 8'h00;
        endcase
        z = (result == 8'h00);
    end

endmodule

// File: rtl/noobs_cpu_core.sv
// Top of the noobs 8-bit multicycle CPU: FSM, PC, register file, flags and
// the data memory port; arithmetic is delegated to noobs_cpu_alu.
module noobs_cpu_core
    import noobs_cpu_pkg::*;
#(
    parameter logic [11:0] PC_RESET = 12'h000
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic [7:0]  i_data,
    output logic [11:0] i_addr,
    input  logic [7:0]  m_rd_data,
    output logic [7:0]  m_wr_data,
    output logic [11:0] m_addr,
    output logic        m_rd,
    output logic        m_wr,
    output logic        m_en
);

    cpu_state_t  state;
    cpu_state_t  next_state;
    logic [11:0] pc;
    logic [7:0]  ir;
    logic [11:0] opr;
    logic [7:0]  regs [4];
    logic        z_flag;
    logic        c_flag;

    logic [3:0]  op;
    logic [1:0]  rd_idx;
    logic [1:0]  rs_idx;
    logic [7:0]  rd_val;
    logic [7:0]  rs_val;
    logic [7:0]  alu_result;
    logic        alu_z;
    logic        alu_c;

    logic        reg_we;
    logic [7:0]  reg_wdata;
    logic        flag_we;
    logic        pc_load;

    assign op     = ir[7:4];
    assign rd_idx = ir[3:2];
    assign rs_idx = ir[1:0];
    assign rd_val = regs[rd_idx];
    assign rs_val = regs[rs_idx];
    assign i_addr = pc;

    noobs_cpu_alu u_alu (
        .a      (rd_val),
        .b      (rs_val),
        .op     (op),
        .result (alu_result),
        .z      (alu_z),
        .c      (alu_c)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // In FETCH the opcode is not yet in IR, so the length decode looks at i_data directly.
    always_comb begin
        next_state = state;
        reg_we     = 1'b0;
        reg_wdata  = 8'h00;
        flag_we    = 1'b0;
        pc_load    = 1'b0;
        m_en       = 1'b0;
        m_rd       = 1'b0;
        m_wr       = 1'b0;
        m_addr     = 12'h000;
        m_wr_data  = 8'h00;
        case (state)
            ST_FETCH: next_state = (instr_len(i_data[7:4]) == 2'd1) ? ST_EXEC : ST_OPR1;
            ST_OPR1:  next_state = (instr_len(op) == 2'd3) ? ST_OPR2 : ST_EXEC;
            ST_OPR2:  next_state = ST_EXEC;
            ST_EXEC: begin
                next_state = ST_FETCH;
                case (op)
                    OP_MOV: begin
                        reg_we    = 1'b1;
                        reg_wdata = rs_val;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        reg_we    = 1'b1;
                        reg_wdata = alu_result;
                        flag_we   = 1'b1;
                    end
                    OP_CMP: flag_we = 1'b1;
                    OP_LDI: begin
                        reg_we    = 1'b1;
                        reg_wdata = opr[7:0];
                    end
                    OP_LD: begin
                        m_en      = 1'b1;
                        m_rd      = 1'b1;
                        m_addr    = opr;
                        reg_we    = 1'b1;
                        reg_wdata = m_rd_data;
                    end
                    OP_ST: begin
                        m_en      = 1'b1;
                        m_wr      = 1'b1;
                        m_addr    = opr;
                        m_wr_data = rd_val;
                    end
                    OP_JMP: pc_load = 1'b1;
                    OP_JZ:  pc_load = z_flag;
                    OP_JC:  pc_load = c_flag;
                    OP_HLT: next_state = ST_HALT;
                    default: ;
                endcase
            end
            ST_HALT:  next_state = ST_HALT;
            default:  next_state = ST_FETCH;
        endcase
    end

    // PC increments in every fetch/operand cycle; the high address nibble of a
    // 3-byte op comes from byte1, while jumps take theirs from the opcode byte.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            pc     <= PC_RESET;
            ir     <= 8'h00;
            opr    <= 12'h000;
            z_flag <= 1'b0;
            c_flag <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    ir <= i_data;
                    pc <= pc + 12'd1;
                end
                ST_OPR1: begin
                    if (instr_len(op) == 2'd3) begin
                        opr[11:8] <= i_data[3:0];
                    end else begin
                        opr[7:0] <= i_data;
                    end
                    pc <= pc + 12'd1;
                end
                ST_OPR2: begin
                    opr[7:0] <= i_data;
                    pc       <= pc + 12'd1;
                end
                ST_EXEC: begin
                    if (reg_we) begin
                        regs[rd_idx] <= reg_wdata;
                    end
                    if (flag_we) begin
                        z_flag <= alu_z;
                        c_flag <= alu_c;
                    end
                    if (pc_load) begin
                        pc <= {ir[3:0], opr[7:0]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_noobs_cpu_core.sv
// Directed self-checking bench for noobs_cpu_core: small programs with
// hand-computed memory results, cycle counts and PC values.
module tb_noobs_cpu_core;

    logic        clk = 1'b0;
    logic        reset_;
    logic        reset2_;
    logic [7:0]  i_data, m_rd_data, m_wr_data;
    logic [11:0] i_addr, m_addr;
    logic        m_rd, m_wr, m_en;
    logic [7:0]  i_data2, m_rd_data2, m_wr_data2;
    logic [11:0] i_addr2, m_addr2;
    logic        m_rd2, m_wr2, m_en2;

    logic [7:0]  imem  [4096];
    logic [7:0]  dmem  [4096];
    logic [7:0]  imem2 [4096];
    logic [7:0]  dmem2 [4096];
    logic [7:0]  prog [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noobs_cpu_core dut (
        .clk       (clk),
        .reset_    (reset_),
        .i_data    (i_data),
        .i_addr    (i_addr),
        .m_rd_data (m_rd_data),
        .m_wr_data (m_wr_data),
        .m_addr    (m_addr),
        .m_rd      (m_rd),
        .m_wr      (m_wr),
        .m_en      (m_en)
    );

    noobs_cpu_core #(.PC_RESET(12'hFFE)) dut_wrap (
        .clk       (clk),
        .reset_    (reset2_),
        .i_data    (i_data2),
        .i_addr    (i_addr2),
        .m_rd_data (m_rd_data2),
        .m_wr_data (m_wr_data2),
        .m_addr    (m_addr2),
        .m_rd      (m_rd2),
        .m_wr      (m_wr2),
        .m_en      (m_en2)
    );

    assign i_data     = imem[i_addr];
    assign m_rd_data  = dmem[m_addr];
    assign i_data2    = imem2[i_addr2];
    assign m_rd_data2 = dmem2[m_addr2];

    always @(posedge clk) begin
        if (m_en && m_wr) dmem[m_addr] = m_wr_data;
        if (m_en2 && m_wr2) dmem2[m_addr2] = m_wr_data2;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic loadProgram();
        reset_ = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            imem[i] = 8'h00;
            dmem[i] = 8'h00;
        end
        for (int i = 0; i < prog.size(); i++) imem[i] = prog[i];
    endtask

    // Holds reset for two cycles and releases on a falling edge, so the
    // caller resumes during cycle 1 (the first FETCH).
    task automatic applyStimulus();
        reset_ = 1'b0;
        repeat (2) @(negedge clk);
        reset_ = 1'b1;
        #1;
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int rd_count;
        logic [11:0] rd_addr;
        logic [11:0] pc_snap;
        int changes;

        reset_  = 1'b0;
        reset2_ = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            imem2[i] = 8'h00;
            dmem2[i] = 8'h00;
        end
        imem2[12'hFFE] = 8'h9C; imem2[12'hFFF] = 8'h00; imem2[12'h000] = 8'h08;
        imem2[12'h001] = 8'hAC; imem2[12'h002] = 8'h00; imem2[12'h003] = 8'h30;
        imem2[12'h004] = 8'hF0;
        dmem2[12'h008] = 8'h77;

        // Reset during ST execute: LDI R1,0x33; ST R1,[0x040]; HLT
        prog = '{8'h84, 8'h33, 8'hA4, 8'h00, 8'h40, 8'hF0};
        loadProgram();
        dmem[12'h040] = 8'hEE;
        #1;
        checkOutput("reset_i_addr", 32'(i_addr), 32'h000);
        checkOutput("reset_strobes", {m_en, m_rd, m_wr}, 32'h0);
        applyStimulus();
        runCycles(6);
        checkOutput("st_exec_m_wr", 32'(m_wr), 32'h1);
        checkOutput("st_exec_m_addr", 32'(m_addr), 32'h040);
        #2 reset_ = 1'b0;
        #1;
        checkOutput("abort_m_wr", 32'(m_wr), 32'h0);
        checkOutput("abort_m_en", 32'(m_en), 32'h0);
        checkOutput("abort_pc", 32'(i_addr), 32'h000);
        @(posedge clk);
        #1;
        checkOutput("abort_no_write", 32'(dmem[12'h040]), 32'hEE);
        @(negedge clk);
        reset_ = 1'b1;
        #1;
        checkOutput("refetch_addr", 32'(i_addr), 32'h000);
        runCycles(1);
        checkOutput("refetch_advance", 32'(i_addr), 32'h001);
        runCycles(20);
        checkOutput("rerun_store", 32'(dmem[12'h040]), 32'h33);

        // LDI R0,5; LDI R2,4; ADD R2,R0; ST R2,[0x010]; HLT
        prog = '{8'h80, 8'h05, 8'h88, 8'h04, 8'h28, 8'hA8, 8'h00, 8'h10, 8'hF0};
        loadProgram();
        applyStimulus();
        cyc = 1;
        while (!m_wr && cyc < 50) begin
            runCycles(1);
            cyc++;
        end
        checkOutput("add_st_cycle", 32'(cyc), 32'd12);
        checkOutput("add_st_data", 32'(m_wr_data), 32'h09);
        runCycles(10);
        checkOutput("add_st_mem", 32'(dmem[12'h010]), 32'h09);
        checkOutput("add_halt_pc", 32'(i_addr), 32'h009);

        // Carry/zero: 0xFF+0x01 -> JZ taken, JC taken, ST R0 to 0x050
        prog = '{8'h80, 8'hFF, 8'h84, 8'h01, 8'h21, 8'hC0, 8'h0A, 8'hF0, 8'hF0, 8'hF0,
                 8'hD0, 8'h0F, 8'hF0, 8'hF0, 8'hF0, 8'hA0, 8'h00, 8'h50, 8'hF0};
        loadProgram();
        dmem[12'h050] = 8'hAA;
        applyStimulus();
        runCycles(40);
        checkOutput("carry_result", 32'(dmem[12'h050]), 32'h00);
        checkOutput("carry_jumps_pc", 32'(i_addr), 32'h013);

        // LD R3,[0x008]; ST R3,[0x009]; HLT
        prog = '{8'h9C, 8'h00, 8'h08, 8'hAC, 8'h00, 8'h09, 8'hF0};
        loadProgram();
        dmem[12'h008] = 8'h5A;
        applyStimulus();
        rd_count = 0;
        rd_addr  = 12'h000;
        for (int i = 0; i < 30; i++) begin
            if (m_rd) begin
                rd_count++;
                rd_addr = m_addr;
            end
            runCycles(1);
        end
        checkOutput("ld_rd_cycles", 32'(rd_count), 32'd1);
        checkOutput("ld_addr", 32'(rd_addr), 32'h008);
        checkOutput("ld_copy", 32'(dmem[12'h009]), 32'h5A);

        // Countdown 3->0 with SUB/JZ/JMP, then ST R0,[0x020]
        prog = '{8'h80, 8'h03, 8'h84, 8'h01, 8'h31, 8'hC0, 8'h0A, 8'hB0, 8'h04, 8'hF0,
                 8'hA0, 8'h00, 8'h20, 8'hF0};
        loadProgram();
        dmem[12'h020] = 8'hCC;
        applyStimulus();
        runCycles(11);
        checkOutput("jz_fallthrough", 32'(i_addr), 32'h007);
        runCycles(100);
        checkOutput("loop_store", 32'(dmem[12'h020]), 32'h00);
        checkOutput("loop_halt_pc", 32'(i_addr), 32'h00E);

        // AND/OR/XOR/MOV/CMP, with JZ after an equal CMP
        prog = '{8'h80, 8'hF0, 8'h84, 8'h3C, 8'h41, 8'hA0, 8'h00, 8'h60, 8'h88, 8'h0F,
                 8'h59, 8'hA8, 8'h00, 8'h61, 8'h65, 8'hA4, 8'h00, 8'h62, 8'h1E, 8'hAC,
                 8'h00, 8'h63, 8'h7E, 8'hC0, 8'h1B, 8'hF0, 8'hF0, 8'hAC, 8'h00, 8'h64, 8'hF0};
        loadProgram();
        dmem[12'h062] = 8'hAA;
        dmem[12'h064] = 8'hAA;
        applyStimulus();
        runCycles(80);
        checkOutput("and_result", 32'(dmem[12'h060]), 32'h30);
        checkOutput("or_result", 32'(dmem[12'h061]), 32'h3F);
        checkOutput("xor_result", 32'(dmem[12'h062]), 32'h00);
        checkOutput("mov_result", 32'(dmem[12'h063]), 32'h3F);
        checkOutput("cmp_jz_store", 32'(dmem[12'h064]), 32'h3F);
        checkOutput("logic_halt_pc", 32'(i_addr), 32'h01F);

        // PC wrap: LD at 0xFFE straddles to 0x000, then ST and HLT
        checkOutput("wrap_reset_pc", 32'(i_addr2), 32'hFFE);
        @(negedge clk);
        reset2_ = 1'b1;
        #1;
        rd_addr = 12'h000;
        for (int i = 0; i < 40; i++) begin
            if (m_rd2) rd_addr = m_addr2;
            runCycles(1);
        end
        checkOutput("wrap_ld_addr", 32'(rd_addr), 32'h008);
        checkOutput("wrap_store", 32'(dmem2[12'h030]), 32'h77);
        checkOutput("wrap_halt_pc", 32'(i_addr2), 32'h005);
        pc_snap = i_addr2;
        changes = 0;
        for (int i = 0; i < 100; i++) begin
            if (i_addr2 !== pc_snap || {m_en2, m_rd2, m_wr2} !== 3'b000 ||
                m_addr2 !== 12'h000 || m_wr_data2 !== 8'h00) changes++;
            runCycles(1);
        end
        checkOutput("halt_stable", 32'(changes), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
